// File: rtl/i2c_slave_seq_pkg.sv
// Shared types and constants for the I2C slave bit/byte sequencer.
// Holds the FSM encoding, ACK/NACK line levels and the underrun fill byte.
package i2c_slave_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ACK_OUT  = 3'd2,
    NACK_OUT = 3'd3,
    RX       = 3'd4,
    TX       = 3'd5,
    MACK     = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  localparam logic       I2C_ACK  = 1'b0;
  localparam logic       I2C_NACK = 1'b1;
  localparam logic [7:0] FF_BYTE  = 8'hFF;

endpackage

// File: rtl/glitch_filter.sv
// Two-flop synchroniser plus SIZE-sample agreement window; output moves only when
// SIZE consecutive samples agree. Latency SIZE+2 clk; no backpressure.
module glitch_filter #(
  parameter int   SIZE    = 3,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [1:0]      sync;
  logic [SIZE-2:0] hist;
  logic [SIZE-1:0] win;

  assign win = {hist, sync[1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= {2{RST_VAL}};
      hist <= {(SIZE-1){RST_VAL}};
      dout <= RST_VAL;
    end else begin
      sync <= {sync[0], din};
      hist <= win[SIZE-2:0];
      if (&win)       dout <= 1'b1;
      else if (~|win) dout <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_slave_seq.sv
// I2C slave bit/byte sequencer: filtered START/STOP detection, address match, RX/TX shifting,
// open-drain SDA drive. I2C_CLK_STRETCH_EN: hold SCL low instead of sending an underrun byte.
module i2c_slave_seq
  import i2c_slave_seq_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         FILTER_SIZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic       start,
  output logic       stop,
  output logic       addr_hit,
  output logic       rw,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_full,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_underrun
);

  logic scl_h, sda_h, scl_q, sda_q;
  logic scl_r, scl_f, sda_r, sda_f, start_ev, stop_ev;

  glitch_filter #(.SIZE(FILTER_SIZE), .RST_VAL(1'b1)) u_scl_filt (
    .clk(clk), .rst(rst), .din(scl_in), .dout(scl_h));
  glitch_filter #(.SIZE(FILTER_SIZE), .RST_VAL(1'b1)) u_sda_filt (
    .clk(clk), .rst(rst), .din(sda_in), .dout(sda_h));

  assign scl_r    = scl_h & ~scl_q;
  assign scl_f    = ~scl_h & scl_q;
  assign sda_r    = sda_h & ~sda_q;
  assign sda_f    = ~sda_h & sda_q;
  assign start_ev = sda_f & scl_h;
  assign stop_ev  = sda_r & scl_h;

  state_t     state, state_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [6:0] shreg, shreg_d;
  logic [6:0] tx_shift, tx_shift_d;
  logic [7:0] tx_buf, tx_buf_d, rx_data_d;
  logic       ack_phase, ack_phase_d, tx_load, tx_load_d, pending, pending_d;
  logic       rw_d, sda_oe_d, do_load;
  logic       start_d, stop_d, addr_hit_d, rx_valid_d, tx_req_d, tx_underrun_d;
`ifdef I2C_CLK_STRETCH_EN
  logic       scl_oe_d, scl_rel, scl_rel_d;
`else
  logic [7:0] ld_byte;
  assign scl_oe = 1'b0;
`endif

  always_comb begin
    state_d       = state;
    bit_cnt_d     = bit_cnt;
    shreg_d       = shreg;
    tx_shift_d    = tx_shift;
    tx_buf_d      = tx_buf;
    ack_phase_d   = ack_phase;
    tx_load_d     = tx_load;
    pending_d     = pending;
    rw_d          = rw;
    sda_oe_d      = sda_oe;
    rx_data_d     = rx_data;
    start_d       = 1'b0;
    stop_d        = 1'b0;
    addr_hit_d    = 1'b0;
    rx_valid_d    = 1'b0;
    tx_req_d      = 1'b0;
    tx_underrun_d = 1'b0;
    do_load       = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    scl_oe_d      = scl_oe;
    scl_rel_d     = 1'b0;
`else
    ld_byte       = 8'h00;
`endif

    if (pending && tx_valid) begin
      tx_buf_d  = tx_data;
      pending_d = 1'b0;
    end
`ifdef I2C_CLK_STRETCH_EN
    // Late byte while stretching: put MSB on SDA now, let SCL go one clk later.
    if (scl_oe && pending && tx_valid) begin
      tx_shift_d = tx_data[6:0];
      sda_oe_d   = ~tx_data[7];
      scl_rel_d  = 1'b1;
    end
    if (scl_rel) scl_oe_d = 1'b0;
`endif

    if (start_ev) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      start_d   = 1'b1;
      tx_load_d = 1'b0;
      pending_d = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
      scl_oe_d  = 1'b0;
      scl_rel_d = 1'b0;
`endif
    end else if (stop_ev) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      stop_d    = 1'b1;
      tx_load_d = 1'b0;
      pending_d = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
      scl_oe_d  = 1'b0;
      scl_rel_d = 1'b0;
`endif
    end else begin
      case (state)
        ADDR: if (scl_r) begin
          shreg_d   = {shreg[5:0], sda_h};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (shreg == SLAVE_ADDR) begin
              addr_hit_d  = 1'b1;
              rw_d        = sda_h;
              state_d     = ACK_OUT;
              ack_phase_d = 1'b0;
              if (sda_h) begin
                tx_req_d  = 1'b1;
                pending_d = 1'b1;
              end
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ACK_OUT, NACK_OUT: if (scl_f) begin
          if (!ack_phase) begin
            ack_phase_d = 1'b1;
            sda_oe_d    = (state == ACK_OUT) ? ~I2C_ACK : 1'b0;
          end else begin
            ack_phase_d = 1'b0;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 3'd0;
            if (state == NACK_OUT) state_d = IGNORE;
            else if (rw) begin
              state_d = TX;
              do_load = 1'b1;
            end else state_d = RX;
          end
        end
        RX: if (scl_r) begin
          shreg_d   = {shreg[5:0], sda_h};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_d   = {shreg, sda_h};
            rx_valid_d  = 1'b1;
            ack_phase_d = 1'b0;
            state_d     = rx_full ? NACK_OUT : ACK_OUT;
          end
        end
        TX: if (scl_f) begin
          if (tx_load) do_load = 1'b1;
          else if (bit_cnt == 3'd7) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = MACK;
          end else begin
            bit_cnt_d  = bit_cnt + 3'd1;
            sda_oe_d   = ~tx_shift[6];
            tx_shift_d = {tx_shift[5:0], 1'b0};
          end
        end
        MACK: if (scl_r) begin
          if (sda_h == I2C_NACK) state_d = IGNORE;
          else begin
            state_d   = TX;
            tx_load_d = 1'b1;
            tx_req_d  = 1'b1;
            pending_d = 1'b1;
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: sda_oe_d = 1'b0;
      endcase

      // Byte load happens on an SCL fall, so SDA may move immediately.
      if (do_load) begin
        tx_load_d = 1'b0;
        bit_cnt_d = 3'd0;
`ifdef I2C_CLK_STRETCH_EN
        if (pending_d) scl_oe_d = 1'b1;
        else begin
          tx_shift_d = tx_buf_d[6:0];
          sda_oe_d   = ~tx_buf_d[7];
        end
`else
        ld_byte = pending_d ? FF_BYTE : tx_buf_d;
        if (pending_d) begin
          tx_underrun_d = 1'b1;
          pending_d     = 1'b0;
        end
        tx_shift_d = ld_byte[6:0];
        sda_oe_d   = ~ld_byte[7];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_q <= 1'b1;  sda_q <= 1'b1;
      state <= IDLE;  bit_cnt <= 3'd0;
      shreg <= 7'd0;  tx_shift <= 7'd0;  tx_buf <= 8'd0;
      ack_phase <= 1'b0;  tx_load <= 1'b0;  pending <= 1'b0;
      rw <= 1'b0;  sda_oe <= 1'b0;  rx_data <= 8'd0;
      start <= 1'b0;  stop <= 1'b0;  addr_hit <= 1'b0;
      rx_valid <= 1'b0;  tx_req <= 1'b0;  tx_underrun <= 1'b0;
`ifdef I2C_CLK_STRETCH_EN
      scl_oe <= 1'b0;  scl_rel <= 1'b0;
`endif
    end else begin
      scl_q <= scl_h;  sda_q <= sda_h;
      state <= state_d;  bit_cnt <= bit_cnt_d;
      shreg <= shreg_d;  tx_shift <= tx_shift_d;  tx_buf <= tx_buf_d;
      ack_phase <= ack_phase_d;  tx_load <= tx_load_d;  pending <= pending_d;
      rw <= rw_d;  sda_oe <= sda_oe_d;  rx_data <= rx_data_d;
      start <= start_d;  stop <= stop_d;  addr_hit <= addr_hit_d;
      rx_valid <= rx_valid_d;  tx_req <= tx_req_d;  tx_underrun <= tx_underrun_d;
`ifdef I2C_CLK_STRETCH_EN
      scl_oe <= scl_oe_d;  scl_rel <= scl_rel_d;
`endif
    end
  end

endmodule
